// File: rtl/ifetch_if.sv
// ifetch_if: bundles the instruction-memory bus (req/gnt/rvalid), the
// redirect/stall controls and the decode-facing outputs of the fetch stage.
// The master modport is the fetch stage; the slave modport is its
// surroundings (instruction memory, execute and decode).
interface ifetch_if;
    // instruction memory bus
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    // control-flow redirect from execute
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    // decode side
    logic        stall_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;

    modport master (
        output imem_req_o, imem_addr_o, inst_o, inst_addr_o, inst_valid_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  redirect_i, redirect_addr_i, stall_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, inst_o, inst_addr_o, inst_valid_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output redirect_i, redirect_addr_i, stall_i
    );
endinterface

// File: rtl/ifetch.sv
// ifetch: instruction fetch stage. Holds the PC, issues word requests to
// instruction memory under a credit limit, buffers in-order responses in a
// small FIFO and presents inst/inst_addr/valid to decode. Redirects flush the
// buffer and mark in-flight responses as stale so they are dropped on return.
// Optional build macro IFETCH_PERF_EN adds fetch/stall performance counters.
//
// Handshakes:
//   memory  - a request transfers on a cycle with imem_req_o && imem_gnt_i;
//             req may drop without a grant and the address need not be held.
//             Responses return in order on imem_rvalid_i, at least one cycle
//             after their grant, and are never back-pressured.
//   decode  - an instruction transfers on a cycle with inst_valid_o && !stall_i;
//             while stalled the outputs hold. A redirect flushes the buffer in
//             the same edge regardless of stall_i.
module ifetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    ifetch_if.master    bus
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt_o,
    output logic [31:0] perf_stall_cnt_o
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(FIFO_DEPTH);

    logic [31:0]      pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;

    // address queue: one entry per granted request, retired per response
    logic [31:0]      aq_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] aq_wr;
    logic [PTR_W-1:0] aq_rd;

    // fetch buffer: {data, addr} of accepted responses
    logic [31:0]      fq_data [FIFO_DEPTH];
    logic [31:0]      fq_addr [FIFO_DEPTH];
    logic [PTR_W-1:0] fq_wr;
    logic [PTR_W-1:0] fq_rd;
    logic [CNT_W-1:0] fifo_count;

    logic [CNT_W:0]   credit_sum;
    logic             req;
    logic             grant;
    logic             rsp;
    logic             push;
    logic             pop;
    logic             valid;
    logic [31:0]      redirect_pc;
    logic             unused_addr_bits;

    // low address bits of a redirect target are architecturally ignored
    assign unused_addr_bits = ^bus.redirect_addr_i[1:0];
    assign redirect_pc      = {bus.redirect_addr_i[31:2], 2'b00};

    // credits cover both buffered words and requests still in flight
    assign credit_sum = {1'b0, outstanding} + {1'b0, fifo_count};
    assign req        = !rst && !bus.redirect_i && (credit_sum < DEPTH_W);
    assign grant      = req && bus.imem_gnt_i;
    assign rsp        = bus.imem_rvalid_i;
    // stale words (pending discard) and words landing on a redirect are dropped
    assign push       = rsp && !bus.redirect_i && (discard == '0);
    assign valid      = (fifo_count != '0);
    assign pop        = valid && !bus.stall_i;

    assign bus.imem_req_o   = req;
    assign bus.imem_addr_o  = pc;
    assign bus.inst_valid_o = valid;
    assign bus.inst_o       = valid ? fq_data[fq_rd] : NOP_INST;
    assign bus.inst_addr_o  = valid ? fq_addr[fq_rd] : 32'h0;

    // PC, in-flight request count and stale-response count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (bus.redirect_i) begin
            pc          <= redirect_pc;
            outstanding <= outstanding - CNT_W'(rsp);
            discard     <= outstanding - CNT_W'(rsp);
        end else begin
            if (grant) begin
                pc <= pc + 32'd4;
            end
            outstanding <= outstanding + CNT_W'(grant) - CNT_W'(rsp);
            if (rsp && (discard != '0)) begin
                discard <= discard - CNT_W'(1);
            end
        end
    end

    // address queue pointers: push on grant, retire on every response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aq_wr <= '0;
            aq_rd <= '0;
        end else begin
            if (grant) begin
                aq_wr <= aq_wr + PTR_W'(1);
            end
            if (rsp) begin
                aq_rd <= aq_rd + PTR_W'(1);
            end
        end
    end

    // address queue storage
    always_ff @(posedge clk) begin
        if (grant) begin
            aq_mem[aq_wr] <= pc;
        end
    end

    // fetch buffer pointers and occupancy; a redirect empties the buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fq_wr      <= '0;
            fq_rd      <= '0;
            fifo_count <= '0;
        end else if (bus.redirect_i) begin
            fq_wr      <= '0;
            fq_rd      <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fq_wr <= fq_wr + PTR_W'(1);
            end
            if (pop) begin
                fq_rd <= fq_rd + PTR_W'(1);
            end
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // fetch buffer storage
    always_ff @(posedge clk) begin
        if (push) begin
            fq_data[fq_wr] <= bus.imem_rdata_i;
            fq_addr[fq_wr] <= aq_mem[aq_rd];
        end
    end

`ifdef IFETCH_PERF_EN
    // delivered-instruction and decode-stall counters, free-running with wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt_o <= 32'h0;
            perf_stall_cnt_o <= 32'h0;
        end else begin
            if (pop) begin
                perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
            end
            if (bus.stall_i && valid) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed bench for the ifetch stage. A table of per-cycle
// inputs with hand-computed outputs covers start-up streaming, stall, grant
// gaps and redirects; hand-written sequences cover stall-with-full-buffer,
// redirect under stall with PC wrap, asynchronous reset mid-run and, when
// IFETCH_PERF_EN is defined, the performance counters.
module tb_ifetch;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        gnt;
        logic        rsp;
        logic        stall;
        logic        redir;
        logic [31:0] raddr;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_iaddr;
    } vec_t;

    logic clk;
    logic rst;
    ifetch_if bus();

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
`endif

    ifetch u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt_o (perf_fetch),
        .perf_stall_cnt_o (perf_stall)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] pend_q[$];   // memory model: granted addresses awaiting rvalid
    logic [31:0] exp_q[$];    // scoreboard: addresses decode should receive
    logic [31:0] model_pc;

    vec_t vecs[33];

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic g, input logic r_en, input logic s, input logic rd,
                                input logic [31:0] ra, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] eia);
        vec_t v;
        v.gnt = g; v.rsp = r_en; v.stall = s; v.redir = rd; v.raddr = ra;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_iaddr = eia;
        return v;
    endfunction

    // driver: apply inputs for this cycle (called just after a falling edge)
    task automatic drive(input logic g, input logic r_en, input logic s, input logic rd,
                         input logic [31:0] ra);
        bus.stall_i         = s;
        bus.redirect_i      = rd;
        bus.redirect_addr_i = ra;
        bus.imem_gnt_i      = g;
        if (r_en && pend_q.size() != 0) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = pend_q[0] ^ KEY;
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = 32'h0;
        end
        #1;
    endtask

    // scoreboard checks for this cycle, then clock edge and model update
    task automatic advance();
        logic        granted;
        logic        rsp;
        logic        popped;
        logic        rd;
        logic [31:0] ra;
        logic [31:0] gaddr;
        granted = bus.imem_req_o && bus.imem_gnt_i;
        rsp     = bus.imem_rvalid_i;
        popped  = bus.inst_valid_o && !bus.stall_i;
        rd      = bus.redirect_i;
        ra      = bus.redirect_addr_i;
        gaddr   = bus.imem_addr_o;
        if (bus.inst_valid_o) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_head: got valid inst_addr %h required no valid output", bus.inst_addr_o);
            end else begin
                check32("sb_head_addr", bus.inst_addr_o, exp_q[0]);
                check32("sb_head_inst", bus.inst_o, exp_q[0] ^ KEY);
            end
        end
        if (granted) begin
            check32("sb_gnt_addr", gaddr, model_pc);
        end
        @(posedge clk);
        if (rsp) void'(pend_q.pop_front());
        if (popped && exp_q.size() != 0) void'(exp_q.pop_front());
        if (rd) begin
            exp_q.delete();
            model_pc = {ra[31:2], 2'b00};
        end
        if (granted) begin
            pend_q.push_back(gaddr);
            exp_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.imem_gnt_i      = 1'b0;
        bus.imem_rvalid_i   = 1'b0;
        bus.imem_rdata_i    = 32'h0;
        bus.redirect_i      = 1'b0;
        bus.redirect_addr_i = 32'h0;
        bus.stall_i         = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_req"},   32'(bus.imem_req_o), 32'h0);
        check32({tag, "_valid"}, 32'(bus.inst_valid_o), 32'h0);
        check32({tag, "_inst"},  bus.inst_o, NOP);
        check32({tag, "_iaddr"}, bus.inst_addr_o, 32'h0);
    endtask

    initial begin
        // vector table: gnt, rsp, stall, redir, raddr | req, addr, valid, inst_addr
        vecs[0]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000);
        vecs[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 32'h000);
        vecs[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h008, 1'b1, 32'h000);
        vecs[3]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h004);
        vecs[4]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b0, 32'h000);
        vecs[5]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h010, 1'b1, 32'h008);
        vecs[6]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h010, 1'b1, 32'h008);
        vecs[7]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h010, 1'b1, 32'h008);
        vecs[8]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h010, 1'b1, 32'h008);
        vecs[9]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h00C);
        vecs[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h014, 1'b0, 32'h000);
        vecs[11] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h014, 1'b1, 32'h010);
        vecs[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h018, 1'b0, 32'h000);
        vecs[13] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h01C, 1'b0, 32'h000);
        vecs[14] = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h103, 1'b0, 32'h01C, 1'b0, 32'h000);
        vecs[15] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 32'h000);
        vecs[16] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h000);
        vecs[17] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h000);
        vecs[18] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h108, 1'b1, 32'h100);
        vecs[19] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h104);
        vecs[20] = mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h180, 1'b0, 32'h10C, 1'b0, 32'h000);
        vecs[21] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h180, 1'b0, 32'h000);
        vecs[22] = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h184, 1'b0, 32'h000);
        vecs[23] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h000);
        vecs[24] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h000);
        vecs[25] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h208, 1'b1, 32'h200);
        vecs[26] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h204);
        for (int i = 27; i <= 30; i++)
            vecs[i] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h208, 1'b0, 32'h000);
        vecs[31] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h208, 1'b0, 32'h000);
        vecs[32] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h20C, 1'b0, 32'h000);

        // reset block
        rst = 1'b1;
        idle_inputs();
        model_pc = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // table-driven vectors
        for (int i = 0; i < 33; i++) begin
            drive(vecs[i].gnt, vecs[i].rsp, vecs[i].stall, vecs[i].redir, vecs[i].raddr);
            check32($sformatf("v%0d_req", i),   32'(bus.imem_req_o),   32'(vecs[i].exp_req));
            check32($sformatf("v%0d_addr", i),  bus.imem_addr_o,       vecs[i].exp_addr);
            check32($sformatf("v%0d_valid", i), 32'(bus.inst_valid_o), 32'(vecs[i].exp_valid));
            check32($sformatf("v%0d_iaddr", i), bus.inst_addr_o,       vecs[i].exp_iaddr);
            check32($sformatf("v%0d_inst", i),  bus.inst_o,
                    vecs[i].exp_valid ? (vecs[i].exp_iaddr ^ KEY) : NOP);
            advance();
        end

        // stall held 6 cycles: buffer plus in-flight already at the credit limit
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            check32($sformatf("stall%0d_req", k), 32'(bus.imem_req_o), 32'h0);
            advance();
        end
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            advance();
        end

        // redirect while stalled (redirect wins), target wraps the PC
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
        advance();
        check32("redir_stall_valid", 32'(bus.inst_valid_o), 32'h0);
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 12 && !seen; k++) begin
                if (bus.inst_valid_o) seen = 1'b1;
                else begin
                    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
                    advance();
                end
            end
            if (!seen) begin
                n_vec++;
                n_err++;
                $display("FAIL wrap_wait: got no valid output in 12 cycles required valid");
            end else begin
                check32("wrap_first_iaddr", bus.inst_addr_o, 32'hFFFF_FFFC);
            end
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            advance();
        end

        // asynchronous reset in the middle of a cycle
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        idle_inputs();
        pend_q.delete();
        exp_q.delete();
        model_pc = 32'h0;
        @(negedge clk);
        rst = 1'b0;

`ifdef IFETCH_PERF_EN
        check32("perf_fetch_rst", perf_fetch, 32'h0);
        check32("perf_stall_rst", perf_stall, 32'h0);
        begin
            int pops = 0;
            int stalls = 0;
            logic st;
            for (int c = 0; c < 80 && pops < 10; c++) begin
                st = (stalls < 3) && (pops >= 2) && bus.inst_valid_o;
                drive(1'b1, 1'b1, st, 1'b0, 32'h0);
                if (bus.inst_valid_o && st) stalls++;
                if (bus.inst_valid_o && !st) pops++;
                advance();
            end
            if (pops < 10) begin
                n_vec++;
                n_err++;
                $display("FAIL perf_wait: got %0d pops required 10", pops);
            end
            check32("perf_fetch_cnt", perf_fetch, 32'd10);
            check32("perf_stall_cnt", perf_stall, 32'd3);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check32("perf_fetch_clr", perf_fetch, 32'h0);
        check32("perf_stall_clr", perf_stall, 32'h0);
        idle_inputs();
        pend_q.delete();
        exp_q.delete();
        model_pc = 32'h0;
        @(negedge clk);
        rst = 1'b0;
`else
        // short streaming run after reset release
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            advance();
        end
`endif

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
